ramb_arbiter: RTL
=================

# ramb_arbiter

Arbiter and sequencer for port B of the 4096×16 dual-port block RAM. It shares the port between two requesters: the CPU data bus (master 0) and an auxiliary master (master 1, e.g. a peripheral logger or DMA). It also runs the full-RAM clear sequence in place of ad-hoc clock gating. It sits between the requesters and the RAM, and drives port B address, data and write-enable exclusively.

## Interface
Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 16, RAM word width
- DEPTH, 4096, number of words cleared by the clear sequence (≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock; all logic on rising edge
- res  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  access request, held high until ack
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  ADDR_W  word address; stable while req high
- m0_wdata, m1_wdata  in  DATA_W  write data; stable while req high
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DATA_W  read data, valid in the ack cycle, held until next ack to that master
- clr_req  in  1  one-cycle pulse requesting a zero-fill of RAM words 0..DEPTH-1
- clr_busy  out  1  high while a clear is pending or running
- ram_addr  out  ADDR_W  to RAM port B address
- ram_wdata  out  DATA_W  to RAM port B data
- ram_we  out  1  to RAM port B write enable
- ram_q  in  DATA_W  RAM port B registered read data (1-cycle latency)

## Operation
- States: IDLE, ACCESS, RESP, CLEAR.
- IDLE:
  - Clear pending → CLEAR.
  - Otherwise, if any req is high, pick a winner, latch its we/addr/wdata and the winner id, then → ACCESS.
- ACCESS: drive ram_addr/ram_wdata from the latched values; ram_we = latched we. → RESP.
- RESP: ram_q is valid for reads. Register it into the winner's rdata only if latched we = 0, and pulse the winner's ack next cycle. → IDLE.
- Arbitration: round-robin, last-served pointer. After master k is served, master 1−k wins the next conflict. After reset the pointer makes m0 win the first conflict.
- Clear handling:
  - clr_req sets a pending flag in any state.
  - An in-flight access (ACCESS/RESP) completes normally first.
  - CLEAR writes zero with ram_we=1 at ram_addr = 0,1,…,DEPTH−1, one word per cycle, then → IDLE and clears the pending flag.
  - clr_req while pending or in CLEAR is ignored (no restart).
  - Requests are held off during CLEAR and served afterwards under normal arbitration.
- Outside ACCESS and CLEAR, ram_we = 0. ram_addr/ram_wdata hold their last values.
- The address counter is ADDR_W+1 bits wide so DEPTH = 2^ADDR_W terminates without wrap.

## Timing
- All outputs are registered. On res low, asynchronously: state = IDLE, all acks 0, rdata 0, ram_we 0, ram_addr 0, ram_wdata 0, clr_busy 0, pending 0, RR pointer reset.
- Access latency, with req first seen high at edge E0 in IDLE:
  - ACCESS occupies cycle E0–E1 (RAM samples at E1).
  - RESP occupies E1–E2.
  - ack and rdata are high/valid in cycle E2–E3.
  - Request-to-ack is 3 cycles; throughput is one access per 3 cycles.
- The state is IDLE during the ack cycle. The requester must drop req (or present a new request) before E3; req high at E3 is a new request.
- clr_busy rises the cycle after clr_req and falls the cycle after the last clear write (address DEPTH−1). A clear lasts DEPTH cycles in CLEAR.
- Reset mid-clear or mid-access aborts immediately. No ack is issued, and the clear is not resumed.

## Configuration
- Macro RAMB_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, m0 always wins when both request. The RR pointer is not built, and m1 can starve.

## Test plan
- m0 read of address 0x005 holding 0xBEEF (preloaded) → m0_ack on the 3rd cycle after req seen, m0_rdata = 0xBEEF, m1_ack stays 0.
- m1 write 0x1234 to 0x0A0, then m0 read 0x0A0 → ram_we high exactly one cycle with ram_addr = 0x0A0; the read returns 0x1234.
- m0_req and m1_req held continuously (4 accesses each) → with RAMB_ARB_RR_EN, grants alternate m0,m1,m0,m1…; without it, all m0 accesses are acked before any m1 ack.
- clr_req pulsed during an m1 ACCESS → the m1 ack still arrives. Then 4096 consecutive writes of 0x0000 at addresses 0..4095, clr_busy low the cycle after 4095. A pending m0 read is acked afterwards with 0x0000.
- res asserted at clear address 0x800 → all outputs 0 immediately. After release there is no clear activity and clr_busy = 0. Addresses ≥ 0x800 keep their old contents.
- Second clr_req pulse mid-clear → no counter restart; total clear length is still 4096 cycles.

Source files
------------

// File: rtl/ramb_arbiter.sv
// Port-B arbiter and zero-fill sequencer for the 4096x16 dual-port block RAM.
// Optional feature macro RAMB_ARB_RR_EN: round-robin arbitration (undefined: m0 fixed priority).
module ramb_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              res,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

    // One extra bit so DEPTH == 2**ADDR_W is reachable without wrapping.
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(DEPTH);

    state_t          state;
    state_t          state_next;
    logic            grant;
    logic            grant_id;
    logic            clr_start;
    logic            clr_done;
    logic            clr_pending;
    logic            sel_id;
    logic            sel_we;
    logic [ADDR_W:0] clr_cnt;

`ifdef RAMB_ARB_RR_EN
    logic            last_id;

    // On a conflict the master not served last wins.
    always_comb begin
        grant_id = ~m0_req;
        if (m0_req && m1_req) begin
            grant_id = ~last_id;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            last_id <= 1'b1;
        end else if (grant) begin
            last_id <= grant_id;
        end
    end
`else
    always_comb begin
        grant_id = ~m0_req;
    end
`endif

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        clr_start  = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pending) begin
                    clr_start  = 1'b1;
                    state_next = CLEAR;
                end else if (m0_req || m1_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP:   state_next = IDLE;
            CLEAR: begin
                if (clr_cnt == CNT_END) begin
                    clr_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Port-B drivers double as the latched request; ram_we is a one-cycle strobe.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            sel_id    <= 1'b0;
            sel_we    <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            ram_we <= 1'b0;
            if (grant) begin
                ram_addr  <= grant_id ? m1_addr  : m0_addr;
                ram_wdata <= grant_id ? m1_wdata : m0_wdata;
                ram_we    <= grant_id ? m1_we    : m0_we;
                sel_id    <= grant_id;
                sel_we    <= grant_id ? m1_we    : m0_we;
            end else if (clr_start) begin
                ram_addr  <= '0;
                ram_wdata <= '0;
                ram_we    <= 1'b1;
                clr_cnt   <= CNT_ONE;
            end else if (state == CLEAR && !clr_done) begin
                ram_addr  <= clr_cnt[ADDR_W-1:0];
                ram_we    <= 1'b1;
                clr_cnt   <= clr_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (state == RESP) begin
                if (sel_id) begin
                    m1_ack <= 1'b1;
                    if (!sel_we) begin
                        m1_rdata <= ram_q;
                    end
                end else begin
                    m0_ack <= 1'b1;
                    if (!sel_we) begin
                        m0_rdata <= ram_q;
                    end
                end
            end
        end
    end

    // A second clr_req while one is pending or running is deliberately dropped.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            clr_pending <= 1'b0;
        end else if (clr_done) begin
            clr_pending <= 1'b0;
        end else if (clr_req) begin
            clr_pending <= 1'b1;
        end
    end

    assign clr_busy = clr_pending;

endmodule
